scan_chain_ctrl: RTL and testbench



---
 rtl/scan_chain_ctrl_pkg.sv | 19 +
 rtl/scan_chain_ctrl_piso_sipo.sv | 31 +++
 rtl/scan_chain_ctrl.sv | 116 +++++++++++
 tb/tb_scan_chain_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/scan_chain_ctrl_pkg.sv
// Shared definitions for the scan chain sequencer: FSM state encodings and
// the state enum used by the controller and any bound checkers.
package scan_ctrl_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SHIFT_IN = 3'd1;
  localparam logic [2:0] ST_CAPTURE  = 3'd2;
  localparam logic [2:0] ST_UNLOAD   = 3'd3;
  localparam logic [2:0] ST_FINISH   = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    SHIFT_IN = ST_SHIFT_IN,
    CAPTURE  = ST_CAPTURE,
    UNLOAD   = ST_UNLOAD,
    FINISH   = ST_FINISH
  } scan_state_t;

endpackage

// File: rtl/scan_chain_ctrl_piso_sipo.sv
// Right-shifting register with parallel load; bit 0 is the serial output and
// i_sin enters at the MSB, so it serves both as PISO and as SIPO.
module scan_piso_sipo #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_shift,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_par,
  output logic             o_sout
);

  logic [WIDTH-1:0] r_sh;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_load_val;
    end else if (i_shift) begin
      r_sh <= {i_sin, r_sh[WIDTH-1:1]};
    end
  end

  assign o_par  = r_sh;
  assign o_sout = r_sh[0];

endmodule

// File: rtl/scan_chain_ctrl.sv
// Load / capture / unload sequencer for one mux-scan chain. Owns the chain's
// SE and SI nets and returns the unloaded chain contents on RESP.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN  = 32,
  parameter int CAP_CYCLES = 1,
  parameter int CNT_W      = $clog2(CHAIN_LEN + CAP_CYCLES + 1)
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP,
  output logic [2:0]           DBG_STATE
);

  // Request protocol: START is a level sampled only in IDLE; BUSY high means
  // the request is not taken. DONE marks the single cycle where RESP is new.
  scan_state_t          r_state;
  scan_state_t          w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_se;
  logic [CHAIN_LEN-1:0] r_resp;

  logic                 w_accept;
  logic                 w_last_shift;
  logic                 w_last_cap;
  logic [CHAIN_LEN-1:0] w_pat_par;
  logic                 w_pat_sout;
  logic [CHAIN_LEN-1:0] w_resp_sh;
  logic                 w_resp_sout;
  logic                 w_unused;

  assign w_last_shift = (r_cnt == CNT_W'(CHAIN_LEN - 1));
  assign w_last_cap   = (r_cnt == CNT_W'(CAP_CYCLES - 1));

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (START) begin
          w_next   = SHIFT_IN;
          w_accept = 1'b1;
        end
      end
      SHIFT_IN: if (w_last_shift) w_next = CAPTURE;
      CAPTURE:  if (w_last_cap)   w_next = UNLOAD;
      UNLOAD:   if (w_last_shift) w_next = FINISH;
      FINISH:   w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // SE is decoded from the next state so it lines up with the state register.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_se    <= 1'b0;
      r_resp  <= '0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || (r_state == IDLE)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_se <= (w_next == SHIFT_IN) || (w_next == UNLOAD);
      if ((r_state == UNLOAD) && (w_next == FINISH)) begin
        r_resp <= {SO, w_resp_sh[CHAIN_LEN-1:1]};
      end
    end
  end

  // Pattern register shifts zeros in behind the pattern, so SI settles to 0
  // once the last pattern bit has been sent.
  scan_piso_sipo #(.WIDTH(CHAIN_LEN)) u_pat (
    .i_clk      (CLK),
    .i_rst_n    (RN),
    .i_load     (w_accept),
    .i_load_val (PAT),
    .i_shift    (r_state == SHIFT_IN),
    .i_sin      (1'b0),
    .o_par      (w_pat_par),
    .o_sout     (w_pat_sout)
  );

  scan_piso_sipo #(.WIDTH(CHAIN_LEN)) u_resp (
    .i_clk      (CLK),
    .i_rst_n    (RN),
    .i_load     (w_accept),
    .i_load_val ({CHAIN_LEN{1'b0}}),
    .i_shift    (r_state == UNLOAD),
    .i_sin      (SO),
    .o_par      (w_resp_sh),
    .o_sout     (w_resp_sout)
  );

  // Bit 0 of the response shifter is always shifted out before RESP loads.
  assign w_unused = ^{w_pat_par, w_resp_sout, w_resp_sh[0]};

  assign SE        = r_se;
  assign SI        = w_pat_sout;
  assign BUSY      = (r_state != IDLE);
  assign DONE      = (r_state == FINISH);
  assign RESP      = r_resp;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: two instances (N=4/C=1 and N=8/C=3), each wired
// to a behavioral sdffq chain whose D inputs are constants or the flop's own Q.
module tb_scan_chain_ctrl;
  import scan_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn;
  logic       a_start, a_so, a_se, a_si, a_busy, a_done, a_hold;
  logic [3:0] a_pat, a_resp;
  logic [2:0] a_dbg;
  logic       b_start, b_so, b_se, b_si, b_busy, b_done;
  logic [7:0] b_pat, b_resp;
  logic [2:0] b_dbg;

  localparam logic [3:0] A_D = 4'b1010;
  localparam logic [7:0] B_D = 8'b1100_1010;

  scan_chain_ctrl #(.CHAIN_LEN(4), .CAP_CYCLES(1)) u_dut_a (
    .CLK(clk), .RN(rn), .START(a_start), .PAT(a_pat), .SO(a_so),
    .SE(a_se), .SI(a_si), .BUSY(a_busy), .DONE(a_done), .RESP(a_resp),
    .DBG_STATE(a_dbg)
  );

  scan_chain_ctrl #(.CHAIN_LEN(8), .CAP_CYCLES(3)) u_dut_b (
    .CLK(clk), .RN(rn), .START(b_start), .PAT(b_pat), .SO(b_so),
    .SE(b_se), .SI(b_si), .BUSY(b_busy), .DONE(b_done), .RESP(b_resp),
    .DBG_STATE(b_dbg)
  );

  // Chain models: head is flop 0, tail is the MSB; a_hold makes D = Q.
  logic [3:0] a_chain = '0;
  logic [7:0] b_chain = '0;
  always @(posedge clk) begin
    if (a_se)         a_chain <= {a_chain[2:0], a_si};
    else if (!a_hold) a_chain <= A_D;
    if (b_se)         b_chain <= {b_chain[6:0], b_si};
    else              b_chain <= B_D;
  end
  assign a_so = a_chain[3];
  assign b_so = b_chain[7];

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] a_exp_resp = '0;
  logic [7:0] b_exp_resp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one sequence from IDLE and checks every cycle against the timing
  // model; start_mask bit c drives START high during busy cycle c.
  task automatic run_seq(input bit sel, input logic [7:0] pat,
                         input logic [7:0] exp_resp, input logic [31:0] start_mask);
    int n, cc, len;
    logic [7:0] prev;
    logic e_se, e_si, e_busy, e_done;
    logic [7:0] e_resp;
    logic [2:0] e_st;
    n    = sel ? 8 : 4;
    cc   = sel ? 3 : 1;
    len  = 2 * n + cc + 1;
    prev = sel ? b_exp_resp : a_exp_resp;
    @(negedge clk);
    if (sel) begin b_pat = pat; b_start = 1'b1; end
    else begin a_pat = pat[3:0]; a_start = 1'b1; end
    for (int c = 1; c <= len + 1; c++) begin
      @(negedge clk);
      if (sel) b_start = start_mask[c]; else a_start = start_mask[c];
      if (c <= n)              e_st = ST_SHIFT_IN;
      else if (c <= n + cc)    e_st = ST_CAPTURE;
      else if (c <= 2*n + cc)  e_st = ST_UNLOAD;
      else if (c == len)       e_st = ST_FINISH;
      else                     e_st = ST_IDLE;
      e_se   = (e_st == ST_SHIFT_IN) || (e_st == ST_UNLOAD);
      e_si   = (c <= n) ? pat[c-1] : 1'b0;
      e_busy = (c <= len);
      e_done = (c == len);
      e_resp = (c >= len) ? exp_resp : prev;
      check($sformatf("state%0d c=%0d", sel, c), sel ? b_dbg : a_dbg, e_st);
      check($sformatf("se%0d c=%0d", sel, c), sel ? b_se : a_se, e_se);
      check($sformatf("si%0d c=%0d", sel, c), sel ? b_si : a_si, e_si);
      check($sformatf("busy%0d c=%0d", sel, c), sel ? b_busy : a_busy, e_busy);
      check($sformatf("done%0d c=%0d", sel, c), sel ? b_done : a_done, e_done);
      check($sformatf("resp%0d c=%0d", sel, c), sel ? b_resp : {4'b0, a_resp}, e_resp);
    end
    if (sel) begin b_start = 1'b0; b_exp_resp = exp_resp; end
    else begin a_start = 1'b0; a_exp_resp = exp_resp; end
  endtask

  typedef struct {
    logic [7:0] pat;
    bit         hold;
    logic [7:0] exp_resp;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int done_at[3];
    int nd;
    // Constant D: RESP is D read tail first. Held chain: the pattern comes
    // back in its original bit order (PAT[0] ends up in the tail flop).
    vecs[0] = '{8'h06, 1'b0, 8'h05};
    vecs[1] = '{8'h01, 1'b1, 8'h01};
    vecs[2] = '{8'h0B, 1'b1, 8'h0B};
    vecs[3] = '{8'h0F, 1'b0, 8'h05};
    vecs[4] = '{8'h00, 1'b1, 8'h00};
    vecs[5] = '{8'h09, 1'b1, 8'h09};

    rn = 1'b0; a_start = 1'b0; b_start = 1'b0; a_hold = 1'b0;
    a_pat = '0; b_pat = '0;
    repeat (3) @(negedge clk);
    check("rst_a_se", a_se, 0);     check("rst_a_si", a_si, 0);
    check("rst_a_busy", a_busy, 0); check("rst_a_done", a_done, 0);
    check("rst_a_resp", a_resp, 0); check("rst_a_state", a_dbg, ST_IDLE);
    check("rst_b_se", b_se, 0);     check("rst_b_busy", b_busy, 0);
    check("rst_b_resp", b_resp, 0); check("rst_b_state", b_dbg, ST_IDLE);
    rn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      a_hold = vecs[i].hold;
      run_seq(1'b0, vecs[i].pat, vecs[i].exp_resp, 32'h0);
    end
    a_hold = 1'b0;

    // Longer capture window: SE low for three cycles, DONE at cycle 20.
    run_seq(1'b1, 8'h3C, 8'h53, 32'h0);
    run_seq(1'b1, 8'hA7, 8'h53, 32'h0000_0120);

    // START during SHIFT_IN and during FINISH is ignored.
    run_seq(1'b0, 8'h09, 8'h05, (32'h1 << 3) | (32'h1 << 10));

    // START held high: one sequence per 11 cycles.
    @(negedge clk);
    a_pat = 4'b0011; a_start = 1'b1;
    nd = 0;
    done_at = '{0, 0, 0};
    for (int c = 1; c <= 40 && nd < 3; c++) begin
      @(negedge clk);
      if (a_done) begin
        done_at[nd] = c;
        nd++;
        if (nd == 3) a_start = 1'b0;
      end
    end
    check("held_done_count", nd, 3);
    check("held_first_done", done_at[0], 10);
    check("held_period_1", done_at[1] - done_at[0], 11);
    check("held_period_2", done_at[2] - done_at[1], 11);
    @(negedge clk);
    check("held_idle_busy", a_busy, 0);
    check("held_resp", a_resp, 4'b0101);
    a_exp_resp = 8'h05;

    // Reset in the middle of UNLOAD, with START high on the same edge.
    @(negedge clk);
    a_pat = 4'b0110; a_start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      a_start = 1'b0;
    end
    check("pre_rst_state", a_dbg, ST_UNLOAD);
    rn = 1'b0; a_start = 1'b1;
    @(negedge clk);
    check("mid_rst_se", a_se, 0);   check("mid_rst_busy", a_busy, 0);
    check("mid_rst_resp", a_resp, 0); check("mid_rst_done", a_done, 0);
    check("mid_rst_state", a_dbg, ST_IDLE); check("mid_rst_b_resp", b_resp, 0);
    rn = 1'b1; a_start = 1'b0;
    @(negedge clk);
    check("rst_start_dropped", a_busy, 0);
    a_exp_resp = '0;
    b_exp_resp = '0;
    run_seq(1'b0, 8'h06, 8'h05, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
